// File: rtl/serial_add_pkg.sv
// Shared types and parameter defaults for the serial-add sequencer.
package serial_add_pkg;

    localparam int unsigned WIDTH_DEF   = 4;
    localparam int unsigned DEPTH_DEF   = 4;
    localparam int unsigned TIMEOUT_DEF = 15;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        RESP
    } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with full/empty flags; DEPTH must be a power of two.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             do_push, do_pop;

    // The extra pointer bit tells a full FIFO apart from an empty one.
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // NOTE: storage is deliberately not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
            if (do_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/serial_add_sequencer.sv
// Queues operand pairs and sequences them through an external bit-serial adder,
// with a bounded wait for completion and a valid/ready result port.
module serial_add_sequencer
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH   = WIDTH_DEF,
    parameter int unsigned DEPTH   = DEPTH_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             load,
    output logic             start,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    input  logic [WIDTH:0]   add_sum,
    input  logic             add_done,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH:0]   res_sum,
    output logic             err,
    output logic             err_sticky,
    output logic [7:0]       op_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    state_e             state_q;
    logic               ready_en_q;
    logic               load_q, start_q, err_q, err_sticky_q, res_valid_q;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [WIDTH:0]     res_sum_q;
    logic [7:0]         op_count_q;
    logic [CNT_W-1:0]   wait_cnt_q;

    logic               fifo_full, fifo_empty;
    logic [2*WIDTH-1:0] fifo_head;

    // ready_en_q holds in_ready low during reset and for the edge that releases it.
    assign in_ready = ready_en_q & ~fifo_full;

    sync_fifo #(
        .WIDTH (2 * WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (in_valid & in_ready),
        .wdata_i ({in_a, in_b}),
        .pop_i   (state_q == LOAD),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ready_en_q   <= 1'b0;
            load_q       <= 1'b0;
            start_q      <= 1'b0;
            a_q          <= '0;
            b_q          <= '0;
            res_valid_q  <= 1'b0;
            res_sum_q    <= '0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            op_count_q   <= '0;
            wait_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking defaults make load/start/err self-clearing pulses while every branch still sees pre-edge values.
            ready_en_q <= 1'b1;
            load_q     <= 1'b0;
            start_q    <= 1'b0;
            err_q      <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= LOAD;
                        load_q  <= 1'b1;
                        a_q     <= fifo_head[2*WIDTH-1:WIDTH];
                        b_q     <= fifo_head[WIDTH-1:0];
                    end
                end
                LOAD: begin
                    state_q <= START;
                    start_q <= 1'b1;
                end
                START: begin
                    state_q    <= WAIT;
                    a_q        <= '0;
                    b_q        <= '0;
                    wait_cnt_q <= '0;
                end
                WAIT: begin
                    if (add_done) begin
                        state_q     <= RESP;
                        res_sum_q   <= add_sum;
                        res_valid_q <= 1'b1;
                    end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                        state_q      <= IDLE;
                        err_q        <= 1'b1;
                        err_sticky_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                RESP: begin
                    if (res_ready) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                        op_count_q  <= op_count_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign load       = load_q;
    assign start      = start_q;
    assign A          = a_q;
    assign B          = b_q;
    assign res_valid  = res_valid_q;
    assign res_sum    = res_sum_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign op_count   = op_count_q;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed bench for serial_add_sequencer; the bench plays the downstream adder.
module tb_serial_add_sequencer;

    localparam int W = 4;

    logic         clk, rst_n;
    logic         in_valid, in_ready;
    logic [W-1:0] in_a, in_b;
    logic         load, start;
    logic [W-1:0] A, B;
    logic [W:0]   add_sum;
    logic         add_done;
    logic         res_valid, res_ready;
    logic [W:0]   res_sum;
    logic         err, err_sticky;
    logic [7:0]   op_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_ops  = 0;

    serial_add_sequencer #(.WIDTH(W), .DEPTH(4), .TIMEOUT(15)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .load       (load),
        .start      (start),
        .A          (A),
        .B          (B),
        .add_sum    (add_sum),
        .add_done   (add_done),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .err        (err),
        .err_sticky (err_sticky),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Push one pair and act as an adder that answers on the first WAIT cycle.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b);
        tick(); in_valid = 1'b1; in_a = a; in_b = b;
        tick(); in_valid = 1'b0;
        tick(); tick();
        tick(); add_done = 1'b1; add_sum = {1'b0, a} + {1'b0, b};
        tick(); add_done = 1'b0;
        tick();
        exp_ops++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(); tick();
        n_checks++;
        if ({in_ready, load, start, A, B, res_valid, res_sum, err, err_sticky, op_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0",
                     {in_ready, load, start, A, B, res_valid, res_sum, err, err_sticky, op_count});
        end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_before_edge: got %b required 0", in_ready);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL ready_after_edge: got %b required 1", in_ready);
        end
    endtask

    task automatic test_single_op();
        tick(); in_valid = 1'b1; in_a = 4'd13; in_b = 4'd11;
        tick(); in_valid = 1'b0;
        tick();
        n_checks++;
        if ({load, start, A, B} !== {1'b1, 1'b0, 4'd13, 4'd11}) begin
            n_fail++;
            $display("FAIL single_load: got %h required %h", {load, start, A, B}, {1'b1, 1'b0, 4'd13, 4'd11});
        end
        tick();
        n_checks++;
        if ({load, start, A, B} !== {1'b0, 1'b1, 4'd13, 4'd11}) begin
            n_fail++;
            $display("FAIL single_start: got %h required %h", {load, start, A, B}, {1'b0, 1'b1, 4'd13, 4'd11});
        end
        tick();
        n_checks++;
        if ({load, start, A, B} !== 10'd0) begin
            n_fail++;
            $display("FAIL single_wait_idle_ab: got %h required 0", {load, start, A, B});
        end
        res_ready = 1'b0; add_done = 1'b1; add_sum = 5'd24;
        tick(); add_done = 1'b0;
        n_checks++;
        if ({res_valid, res_sum} !== {1'b1, 5'b11000}) begin
            n_fail++;
            $display("FAIL single_result: got %h required %h", {res_valid, res_sum}, {1'b1, 5'b11000});
        end
        res_ready = 1'b1;
        tick();
        exp_ops++;
        n_checks++;
        if ({res_valid, op_count} !== {1'b0, 8'd1}) begin
            n_fail++;
            $display("FAIL single_done: got %h required %h", {res_valid, op_count}, {1'b0, 8'd1});
        end
    endtask

    task automatic test_fill();
        logic [W-1:0] ea [5] = '{4'd2, 4'd4, 4'd6, 4'd8, 4'd9};
        logic [W-1:0] eb [5] = '{4'd3, 4'd5, 4'd7, 4'd9, 4'd6};
        tick(); in_valid = 1'b1; in_a = 4'd1; in_b = 4'd2;
        tick(); in_valid = 1'b0;
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            tick(); in_valid = 1'b1; in_a = ea[i]; in_b = eb[i];
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_three: in_ready got %b required 1", in_ready);
        end
        tick(); in_a = ea[4]; in_b = eb[4];
        add_done = 1'b1; add_sum = 5'd3;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full: in_ready got %b required 0", in_ready);
        end
        exp_ops++;
        tick(); add_done = 1'b0;
        tick(); tick();
        n_checks++;
        if ({load, A, B, in_ready} !== {1'b1, ea[0], eb[0], 1'b0}) begin
            n_fail++;
            $display("FAIL fill_load_head: got %h required %h", {load, A, B, in_ready}, {1'b1, ea[0], eb[0], 1'b0});
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_ready_back: in_ready got %b required 1", in_ready);
        end
        tick(); in_valid = 1'b0;
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_refull: in_ready got %b required 0", in_ready);
        end
        add_done = 1'b1; add_sum = {1'b0, ea[0]} + {1'b0, eb[0]};
        exp_ops++;
        tick(); add_done = 1'b0;
        for (int k = 1; k < 5; k++) begin
            int t = 0;
            while (load !== 1'b1 && t < 20) begin
                tick();
                t++;
            end
            n_checks++;
            if ({load, A, B} !== {1'b1, ea[k], eb[k]}) begin
                n_fail++;
                $display("FAIL fill_order_%0d: got %h required %h", k, {load, A, B}, {1'b1, ea[k], eb[k]});
            end
            tick(); tick();
            add_done = 1'b1; add_sum = {1'b0, ea[k]} + {1'b0, eb[k]};
            tick(); add_done = 1'b0;
            exp_ops++;
        end
        tick();
        n_checks++;
        if ({op_count, in_ready} !== {8'(exp_ops), 1'b1}) begin
            n_fail++;
            $display("FAIL fill_drained: got %h required %h", {op_count, in_ready}, {8'(exp_ops), 1'b1});
        end
    endtask

    task automatic test_timeout();
        int bad = 0;
        tick(); in_valid = 1'b1; in_a = 4'd3; in_b = 4'd4;
        tick(); in_a = 4'd5; in_b = 4'd6;
        tick(); in_valid = 1'b0; add_done = 1'b1; add_sum = 5'd31;
        tick();
        tick(); add_done = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (err !== 1'b0 || res_valid !== 1'b0 || err_sticky !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL timeout_early: %0d bad cycles required 0", bad);
        end
        n_checks++;
        if ({err, err_sticky, res_valid} !== 3'b110) begin
            n_fail++;
            $display("FAIL timeout_pulse: got %b required 110", {err, err_sticky, res_valid});
        end
        tick();
        n_checks++;
        if ({err, err_sticky, load, A, B} !== {1'b0, 1'b1, 1'b1, 4'd5, 4'd6}) begin
            n_fail++;
            $display("FAIL timeout_next_op: got %h required %h", {err, err_sticky, load, A, B},
                     {1'b0, 1'b1, 1'b1, 4'd5, 4'd6});
        end
        tick(); tick();
        add_done = 1'b1; add_sum = 5'd11;
        tick(); add_done = 1'b0;
        n_checks++;
        if ({res_valid, res_sum} !== {1'b1, 5'd11}) begin
            n_fail++;
            $display("FAIL timeout_next_result: got %h required %h", {res_valid, res_sum}, {1'b1, 5'd11});
        end
        tick();
        exp_ops++;
        n_checks++;
        if (op_count !== 8'(exp_ops)) begin
            n_fail++;
            $display("FAIL timeout_count: got %0d required %0d", op_count, exp_ops);
        end
    endtask

    task automatic test_back_pressure();
        int bad = 0;
        tick(); in_valid = 1'b1; in_a = 4'd15; in_b = 4'd15;
        tick(); in_a = 4'd1; in_b = 4'd1;
        tick(); in_valid = 1'b0;
        tick();
        tick(); res_ready = 1'b0; add_done = 1'b1; add_sum = 5'd30;
        tick(); add_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            if (res_valid !== 1'b1 || res_sum !== 5'd30 || load !== 1'b0) bad++;
            if (i == 4) res_ready = 1'b1;
            tick();
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: %0d bad cycles required 0", bad);
        end
        exp_ops++;
        n_checks++;
        if ({res_valid, op_count} !== {1'b0, 8'(exp_ops)}) begin
            n_fail++;
            $display("FAIL bp_release: got %h required %h", {res_valid, op_count}, {1'b0, 8'(exp_ops)});
        end
        tick();
        n_checks++;
        if ({load, A, B} !== {1'b1, 4'd1, 4'd1}) begin
            n_fail++;
            $display("FAIL bp_next_load: got %h required %h", {load, A, B}, {1'b1, 4'd1, 4'd1});
        end
        tick();
        tick(); add_done = 1'b1; add_sum = 5'd2;
        tick(); add_done = 1'b0;
        n_checks++;
        if ({res_valid, res_sum} !== {1'b1, 5'd2}) begin
            n_fail++;
            $display("FAIL b2b_result: got %h required %h", {res_valid, res_sum}, {1'b1, 5'd2});
        end
        tick();
        exp_ops++;
        n_checks++;
        if ({res_valid, op_count} !== {1'b0, 8'(exp_ops)}) begin
            n_fail++;
            $display("FAIL b2b_no_stall: got %h required %h", {res_valid, op_count}, {1'b0, 8'(exp_ops)});
        end
    endtask

    task automatic test_reset_in_wait();
        int bad = 0;
        tick(); in_valid = 1'b1; in_a = 4'd7; in_b = 4'd8;
        tick(); in_a = 4'd2; in_b = 4'd2;
        tick(); in_valid = 1'b0;
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({in_ready, load, start, A, B, res_valid, res_sum, err, err_sticky, op_count} !== '0) begin
            n_fail++;
            $display("FAIL wait_reset_async: got %h required 0",
                     {in_ready, load, start, A, B, res_valid, res_sum, err, err_sticky, op_count});
        end
        tick(); tick();
        rst_n = 1'b1;
        exp_ops = 0;
        tick();
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL wait_reset_ready: got %b required 1", in_ready);
        end
        for (int i = 0; i < 8; i++) begin
            add_done = (i == 1);
            add_sum  = 5'd17;
            if (load !== 1'b0 || res_valid !== 1'b0 || op_count !== 8'd0) bad++;
            tick();
        end
        add_done = 1'b0;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wait_reset_stale: %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 255; i++) begin
            run_op(4'(i), ~4'(i));
        end
        n_checks++;
        if ({op_count, res_sum} !== {8'd255, 5'd15}) begin
            n_fail++;
            $display("FAIL wrap_255: got %h required %h", {op_count, res_sum}, {8'd255, 5'd15});
        end
        run_op(4'd9, 4'd12);
        n_checks++;
        if ({op_count, res_sum} !== {8'd0, 5'd21}) begin
            n_fail++;
            $display("FAIL wrap_zero: got %h required %h", {op_count, res_sum}, {8'd0, 5'd21});
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        add_done  = 1'b0;
        add_sum   = '0;
        res_ready = 1'b1;
        test_reset();
        test_single_op();
        test_fill();
        test_timeout();
        test_back_pressure();
        test_reset_in_wait();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 4, operand width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, operand FIFO entries; must be a power of 2.
REQ-003 SHALL have parameter TIMEOUT, default 15, maximum number of cycles spent in WAIT.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 in_valid / in_ready  input / output  1 / 1  operand-pair push handshake.
REQ-007 in_a, in_b  input  WIDTH each  operand pair.
REQ-008 load, start  output  1 each  control pulses to the downstream bit-serial adder.
REQ-009 A, B  output  WIDTH each  operands driven to the adder.
REQ-010 add_sum  input  WIDTH+1  adder result, including carry-out.
REQ-011 add_done  input  1  adder completion.
REQ-012 res_valid / res_ready  output / input  1 / 1  result pop handshake.
REQ-013 res_sum  output  WIDTH+1  captured result.
REQ-014 err  output  1  one-cycle pulse on timeout.
REQ-015 err_sticky  output  1  set on timeout, cleared only by reset.
REQ-016 op_count  output  8  completed operations; wraps 255->0.

Function
REQ-017 A push SHALL occur when in_valid&in_ready; in_ready = !fifo_full.
REQ-018 FSM states SHALL be IDLE, LOAD, START, WAIT, RESP.
REQ-019 IDLE SHALL go to LOAD when the FIFO is non-empty; otherwise stay.
REQ-020 LOAD SHALL hold for 1 cycle: load=1, A/B = FIFO head, head popped at end of cycle; next state START.
REQ-021 START SHALL hold for 1 cycle: start=1, A/B held; next state WAIT.
REQ-022 In WAIT, when add_done=1, the block SHALL capture add_sum into res_sum, set res_valid=1, and go to RESP.
REQ-023 In WAIT, if add_done has not been seen after TIMEOUT cycles, the block SHALL pulse err for 1 cycle, set err_sticky, produce no result, and return to IDLE.
REQ-024 The WAIT cycle counter SHALL clear on entry to WAIT.
REQ-025 RESP SHALL hold res_valid and res_sum stable until res_ready; on res_valid&res_ready it SHALL increment op_count, clear res_valid, and go to IDLE.
REQ-026 If res_valid&res_ready is true on the cycle RESP is entered, no stall cycle SHALL occur; the transfer completes on the next posedge.
REQ-027 Push and pop in the same cycle SHALL leave the FIFO count unchanged.
REQ-028 A push while full SHALL be impossible (in_ready=0); in_a/in_b are ignored.
REQ-029 FIFO pointers SHALL wrap modulo DEPTH.
REQ-030 load and start SHALL never be asserted together; A/B SHALL be 0 outside LOAD/START.
REQ-031 add_done outside WAIT SHALL be ignored.

Reset
REQ-032 While rst_n=0: state IDLE, FIFO empty, and in_ready=0.
REQ-033 While rst_n=0: load, start, A, B, res_valid, res_sum, err, err_sticky and op_count are all 0.
REQ-034 On release, in_ready SHALL rise on the first posedge after release.
REQ-035 Reset mid-operation SHALL abandon the operation and discard FIFO contents and any pending result.

Structure
REQ-036 Package serial_add_pkg SHALL hold the state enum and the defaults for WIDTH, DEPTH and TIMEOUT.
REQ-037 The FIFO SHALL be the sub-module sync_fifo, parameterised by WIDTH*2 and DEPTH, with full/empty flags.
REQ-038 The FSM and timeout counter SHALL reside in serial_add_sequencer.

Verification
REQ-039 Single op: push A=13, B=11; bench pulses add_done with add_sum=24 -> load 1 cycle with A=13, B=11, then start 1 cycle; res_sum=5'b11000; op_count=1.
REQ-040 Fill: 4 pushes with add_done withheld -> in_ready=0 after the 4th push (1 entry popped at LOAD, so in_ready returns after 1 cycle); a 5th push is accepted only when in_ready=1.
REQ-041 Timeout: push 3+4, never assert add_done -> err pulse 15 cycles after WAIT entry; err_sticky=1; res_valid stays 0; the next queued op proceeds.
REQ-042 Back-pressure: res_ready=0 for 5 cycles after a result of 15+15=30 -> res_sum holds 30 and no new load occurs; transfer completes on the cycle res_ready=1.
REQ-043 Reset in WAIT: assert rst_n=0 mid-WAIT -> all outputs 0 immediately (asynchronous); after release, in_ready=1 and no stale result.
REQ-044 Wrap: 256 completed ops -> op_count=0.
